// File: rtl/pll_rst_pkg.sv
// Shared types and elaboration-time helpers for the PLL reset sequencer.
// The state encodings are visible on o_state for debug LEDs.
package pll_rst_pkg;

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } pll_state_e;

  function automatic int clog2(input int value);
    int w;
    int v;
    w = 0;
    v = value - 1;
    for (int i = 0; i < 31; i++) begin
      if ((v >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

  // One counter serves all timed states, so it is sized for the longest of them.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    int w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// N-stage single-bit synchroniser with asynchronous active-low reset.
// Output is the last stage; all stages clear to 0 in reset.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], i_d};
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset pulse generation, lock qualification and system reset release.
// Outputs are registered from the next state so they move with the state register.
module pll_reset_sequencer
  import pll_rst_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int SYNC_STAGES    = 2,
  parameter int CNT_W          = 8
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_pll_locked,
  input  logic             i_soft_reset,
  output logic             o_pll_reset,
  output logic             o_sys_reset,
  output logic             o_ready,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_retry_count,
  output logic [CNT_W-1:0] o_lockloss_count
);

  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  logic             locked_s;
  pll_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pll_reset_q, pll_reset_d;
  logic             sys_reset_q, sys_reset_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] retry_q, retry_d;
  logic [CNT_W-1:0] loss_q, loss_d;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .i_d      (i_pll_locked),
    .o_q      (locked_s)
  );

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
        else                   state_d = ST_PLL_RST;
      end
      ST_WAIT_LOCK: begin
        // Lock wins over a coincident timeout.
        if (locked_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TMO_LAST) begin
          state_d = ST_PLL_RST;
          retry_d = sat_inc(retry_q);
        end else begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_STABLE: begin
        if (!locked_s)               state_d = ST_WAIT_LOCK;
        else if (cnt_q == STB_LAST)  state_d = ST_RUN;
        else                         state_d = ST_STABLE;
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d = ST_PLL_RST;
          loss_d  = sat_inc(loss_q);
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_PLL_RST;
    endcase

    // A soft request restarts the sequence and suppresses event counting.
    if (i_soft_reset) begin
      state_d = ST_PLL_RST;
      retry_d = retry_q;
      loss_d  = loss_q;
    end else begin
      state_d = state_d;
    end

    if (i_soft_reset || (state_d != state_q)) cnt_d = '0;
    else if (state_q == ST_RUN)               cnt_d = cnt_q;
    else                                      cnt_d = cnt_q + CW'(1);

    pll_reset_d = (state_d == ST_PLL_RST);
    sys_reset_d = (state_d != ST_RUN);
    ready_d     = (state_d == ST_RUN);
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q     <= ST_PLL_RST;
      cnt_q       <= '0;
      pll_reset_q <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      retry_q     <= '0;
      loss_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pll_reset_q <= pll_reset_d;
      sys_reset_q <= sys_reset_d;
      ready_q     <= ready_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
    end
  end

  assign o_pll_reset      = pll_reset_q;
  assign o_sys_reset      = sys_reset_q;
  assign o_ready          = ready_q;
  assign o_state          = state_q;
  assign o_retry_count    = retry_q;
  assign o_lockloss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench: directed bring-up/fault scenarios plus randomized lock,
// soft-reset and async-reset stimulus, compared every cycle against a phase/time model.
module tb_pll_reset_sequencer;

  localparam int PRC  = 4;
  localparam int LT   = 20;
  localparam int SC   = 8;
  localparam int SYNC = 2;
  localparam int CW   = 2;
  localparam int SAT  = 3;

  localparam int PH_RST  = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_STAB = 2;
  localparam int PH_RUN  = 3;

  logic          i_clk;
  logic          i_resetn;
  logic          i_pll_locked;
  logic          i_soft_reset;
  logic          o_pll_reset;
  logic          o_sys_reset;
  logic          o_ready;
  logic [1:0]    o_state;
  logic [CW-1:0] o_retry_count;
  logic [CW-1:0] o_lockloss_count;

  int n_checks = 0;
  int n_errors = 0;

  int m_ph, m_t, m_retry, m_loss;
  bit m_sync [SYNC];

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC),
    .SYNC_STAGES(SYNC), .CNT_W(CW)
  ) dut (
    .i_clk            (i_clk),
    .i_resetn         (i_resetn),
    .i_pll_locked     (i_pll_locked),
    .i_soft_reset     (i_soft_reset),
    .o_pll_reset      (o_pll_reset),
    .o_sys_reset      (o_sys_reset),
    .o_ready          (o_ready),
    .o_state          (o_state),
    .o_retry_count    (o_retry_count),
    .o_lockloss_count (o_lockloss_count)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mreset();
    m_ph = PH_RST; m_t = 0; m_retry = 0; m_loss = 0;
    for (int k = 0; k < SYNC; k++) m_sync[k] = 1'b0;
  endtask

  // Phase/time model: m_t is cycles already spent in the current phase.
  task automatic mstep();
    int nx;
    bit ls;
    ls = m_sync[SYNC-1];
    nx = m_ph;
    if (i_soft_reset) begin
      nx = PH_RST;
    end else if (m_ph == PH_RST) begin
      if (m_t + 1 >= PRC) nx = PH_WAIT;
    end else if (m_ph == PH_WAIT) begin
      if (ls) nx = PH_STAB;
      else if (m_t + 1 >= LT) begin nx = PH_RST; if (m_retry < SAT) m_retry++; end
    end else if (m_ph == PH_STAB) begin
      if (!ls) nx = PH_WAIT;
      else if (m_t + 1 >= SC) nx = PH_RUN;
    end else begin
      if (!ls) begin nx = PH_RST; if (m_loss < SAT) m_loss++; end
    end
    m_t = (i_soft_reset || nx != m_ph) ? 0 : m_t + 1;
    m_ph = nx;
    for (int k = SYNC - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
    m_sync[0] = i_pll_locked;
  endtask

  initial begin
    mreset();
    forever begin
      @(posedge i_clk or negedge i_resetn);
      if (!i_resetn) mreset();
      else           mstep();
    end
  end

  initial begin
    forever begin
      @(posedge i_clk);
      #2;
      if (i_resetn) begin
        chk("state", int'(o_state), m_ph);
        chk("resets_ready", int'({o_pll_reset, o_sys_reset, o_ready}),
            int'({m_ph == PH_RST, m_ph != PH_RUN, m_ph == PH_RUN}));
        chk("counts", int'({o_retry_count, o_lockloss_count}), m_retry * 4 + m_loss);
      end
    end
  end

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic wait_state(input logic [1:0] target, input int max_edges,
                            output int edges, output bit ok);
    edges = 0;
    ok = 1'b0;
    for (int k = 0; k < max_edges && !ok; k++) begin
      @(posedge i_clk);
      #2;
      edges++;
      if (o_state == target) ok = 1'b1;
    end
  endtask

  task automatic measure_bringup(input string tag);
    int e, fp, fs;
    e = 0; fp = -1; fs = -1;
    for (int k = 0; k < 40 && fs < 0; k++) begin
      @(posedge i_clk);
      #2;
      e++;
      if (!o_pll_reset && fp < 0) fp = e;
      if (!o_sys_reset) fs = e;
    end
    chk({tag, "_pll_pulse_edges"}, fp, PRC);
    chk({tag, "_release_edges"}, fs, PRC + 1 + SC);
    chk({tag, "_ready"}, int'(o_ready), 1);
    chk({tag, "_state_run"}, int'(o_state), 3);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_reset"}, int'(o_pll_reset), 1);
    chk({tag, "_sys_reset"}, int'(o_sys_reset), 1);
    chk({tag, "_ready"}, int'(o_ready), 0);
    chk({tag, "_state"}, int'(o_state), 0);
    chk({tag, "_counts"}, int'({o_retry_count, o_lockloss_count}), 0);
  endtask

  initial begin
    int e, seg;
    bit ok;
    i_resetn = 1'b0; i_pll_locked = 1'b1; i_soft_reset = 1'b0;

    // 1: bring-up with lock already high
    repeat (3) tick();
    #1 chk_reset_vals("por");
    tick();
    i_resetn = 1'b1;
    measure_bringup("bringup");
    chk("model_pin_run", m_ph, PH_RUN);

    // 4 then 2: lock loss in RUN, then lock never returns
    tick();
    i_pll_locked = 1'b0;
    e = 0;
    for (int k = 0; k < 10 && e < 100; k++) begin
      @(posedge i_clk); #2; e++;
      if (o_sys_reset) begin chk("lockloss_react_edges", e, SYNC + 1); e = 100; end
    end
    chk("lockloss_seen", int'(e == 100), 1);
    chk("lockloss_count", int'(o_lockloss_count), 1);
    chk("lockloss_pll_reset", int'(o_pll_reset), 1);
    e = 0;
    for (int k = 0; k < 10 && o_pll_reset; k++) begin @(posedge i_clk); #2; e++; end
    chk("repulse_edges", e, PRC);
    e = 0;
    for (int k = 0; k < 60 && o_retry_count == 2'd0; k++) begin @(posedge i_clk); #2; e++; end
    chk("timeout_edges", e, LT);
    chk("timeout_retry1", int'(o_retry_count), 1);
    chk("timeout_repulse", int'(o_pll_reset), 1);
    repeat (100) tick();
    chk("retry_saturated", int'(o_retry_count), SAT);
    chk("model_pin_retry", m_retry, SAT);
    chk("lockloss_unchanged", int'(o_lockloss_count), 1);

    // 3: glitch at STABLE count 5
    tick();
    i_pll_locked = 1'b1;
    wait_state(2'd2, 60, e, ok);
    chk("reach_stable", int'(ok), 1);
    repeat (4) tick();
    i_pll_locked = 1'b0;
    repeat (3) tick();
    i_pll_locked = 1'b1;
    chk("glitch_no_release", int'(o_sys_reset), 1);
    chk("glitch_back_wait", int'(o_state), 1);
    wait_state(2'd2, 20, e, ok);
    chk("restable", int'(ok), 1);
    wait_state(2'd3, 20, e, ok);
    chk("stable_full_edges", e, SC);

    // 5: soft reset on the same edge lock loss is decided
    tick();
    i_pll_locked = 1'b0;
    tick();
    tick();
    i_soft_reset = 1'b1;
    tick();
    i_soft_reset = 1'b0;
    chk("soft_state", int'(o_state), 0);
    chk("soft_lockloss_same", int'(o_lockloss_count), 1);
    i_pll_locked = 1'b1;

    // 6: async reset pulse between edges mid-STABLE
    wait_state(2'd2, 60, e, ok);
    chk("reach_stable2", int'(ok), 1);
    tick();
    tick();
    #1 i_resetn = 1'b0;
    #1 chk_reset_vals("async");
    #1 i_resetn = 1'b1;
    measure_bringup("restart");

    // randomized lock behaviour, soft and async resets
    seg = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (seg == 0) begin
        seg = $urandom_range(1, 40);
        i_pll_locked = ($urandom_range(0, 9) < 7);
      end
      seg--;
      i_soft_reset = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 799) == 0) begin
        #1 i_resetn = 1'b0;
        #2 i_resetn = 1'b1;
      end
    end
    tick();
    i_soft_reset = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
